// File: rtl/mdu_ctrl_pkg.sv
// Shared op codes, FSM state type and helpers for the EXE-stage mult/div controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: EXE_*_OP op codes for the four mult/div ops, mdu_state_e, op classification helpers.
package mdu_ctrl_pkg;

   // Op codes shared with the single-cycle ALU decode space.
   localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   function automatic logic is_md_op(input logic [7:0] op);
      return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
             (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
   endfunction

   function automatic logic is_mult_op(input logic [7:0] op);
      return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
   endfunction

   function automatic logic is_signed_op(input logic [7:0] op);
      return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
   endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// One restoring-divide step: shift {rem,quot} left by one, trial-subtract divisor, keep if nonnegative.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_i/quot_i/dvsr_i current partial state and divisor; rem_o/quot_o next partial state.
module mdu_ctrl_div_iter (
   input  logic [31:0] rem_i,
   input  logic [31:0] quot_i,
   input  logic [31:0] dvsr_i,
   output logic [31:0] rem_o,
   output logic [31:0] quot_o
);

   logic [32:0] shifted;
   logic [32:0] diff;

   always_comb begin
      // rem < divisor always holds, so the shifted remainder fits in 33 bits.
      shifted = {rem_i, quot_i[31]};
      diff    = shifted - {1'b0, dvsr_i};
      if (!diff[32]) begin
         rem_o  = diff[31:0];
         quot_o = {quot_i[30:0], 1'b1};
      end else begin
         // Restore: a failed trial means shifted < divisor, so bit 32 is zero.
         rem_o  = shifted[31:0];
         quot_o = {quot_i[30:0], 1'b0};
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller beside the EXE-stage ALU, delivering {hi,lo} for HILO writeback.
// Latency: from accept cycle 0, DIV/DIVU ready in cycle 33, MULT/MULTU in cycle 2, divide-by-zero in cycle 1.
// Backpressure: stall (combinational) holds IF/ID/EXE until the result cycle; flush annuls in-flight work.
// Ports: clk/rst; num1/num2 operands; alucontrol op; start/flush controls; stall, ready pulse, hi_o/lo_o result.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   input  logic [7:0]  alucontrol,
   input  logic        start,
   input  logic        flush,
   output logic        stall,
   output logic        ready,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   mdu_state_e  state_q;
   logic [4:0]  cnt_q;
   logic        ready_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   // a_q: multiplicand, or dividend magnitude that shifts into the quotient.
   // b_q: multiplier, or divisor magnitude.
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] rem_q;
   logic        sgn_q;
   logic        qneg_q;
   logic        rneg_q;

   logic        accept;
   logic [31:0] iter_rem;
   logic [31:0] iter_quot;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] prod;
   logic        in_signed;

   mdu_ctrl_div_iter u_div_iter (
      .rem_i  (rem_q),
      .quot_i (a_q),
      .dvsr_i (b_q),
      .rem_o  (iter_rem),
      .quot_o (iter_quot)
   );

   assign accept    = start && is_md_op(alucontrol) && !flush;
   assign in_signed = is_signed_op(alucontrol);

   always_comb begin
      // The low 64 bits of a product of sign-extended operands equal the signed product.
      mul_a    = {{32{sgn_q & a_q[31]}}, a_q};
      mul_b    = {{32{sgn_q & b_q[31]}}, b_q};
      prod     = mul_a * mul_b;
      quot_fix = qneg_q ? (32'd0 - iter_quot) : iter_quot;
      rem_fix  = rneg_q ? (32'd0 - iter_rem) : iter_rem;
   end

   always_comb begin
      stall = 1'b0;
      if (!rst && !flush) begin
         case (state_q)
            ST_IDLE: stall = accept;
            ST_MULT: stall = 1'b1;
            ST_DIV:  stall = 1'b1;
            default: stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 5'd0;
         ready_q <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         rem_q   <= 32'd0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else if (flush) begin
         // Annul: drop back to idle, leave the last delivered result in place.
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ready_q <= 1'b0;
               if (accept) begin
                  sgn_q <= in_signed;
                  if (is_mult_op(alucontrol)) begin
                     a_q     <= num1;
                     b_q     <= num2;
                     state_q <= ST_MULT;
                  end else if (num2 == 32'd0) begin
                     hi_q    <= num1;
                     lo_q    <= 32'hFFFF_FFFF;
                     ready_q <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     a_q     <= (in_signed && num1[31]) ? (32'd0 - num1) : num1;
                     b_q     <= (in_signed && num2[31]) ? (32'd0 - num2) : num2;
                     rem_q   <= 32'd0;
                     cnt_q   <= 5'd0;
                     qneg_q  <= in_signed && (num1[31] ^ num2[31]);
                     rneg_q  <= in_signed && num1[31];
                     state_q <= ST_DIV;
                  end
               end
            end
            ST_MULT: begin
               hi_q    <= prod[63:32];
               lo_q    <= prod[31:0];
               ready_q <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DIV: begin
               rem_q <= iter_rem;
               a_q   <= iter_quot;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'(DIV_CYCLES - 1)) begin
                  hi_q    <= rem_fix;
                  lo_q    <= quot_fix;
                  ready_q <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            default: begin
               // DONE: the same instruction is still in EXE, so start is ignored here.
               ready_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign hi_o  = hi_q;
   assign lo_o  = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random ops against an arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] num1;
   logic [31:0] num2;
   logic [7:0]  alucontrol;
   logic        start;
   logic        flush;
   logic        stall;
   logic        ready;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int errors = 0;
   int checks = 0;
   logic [31:0] last_hi = 32'd0;
   logic [31:0] last_lo = 32'd0;

   always #5 clk = ~clk;

   mdu_ctrl #(.DIV_CYCLES(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .num1       (num1),
      .num2       (num2),
      .alucontrol (alucontrol),
      .start      (start),
      .flush      (flush),
      .stall      (stall),
      .ready      (ready),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain 64-bit integer arithmetic; C-style truncating division gives
   // quotient toward zero and remainder with the dividend's sign.
   function automatic void ref_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output int lat);
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] p;
      if (op == EXE_MULT_OP || op == EXE_DIV_OP) begin
         sa = $signed(a);
         sb = $signed(b);
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      if (op == EXE_MULT_OP || op == EXE_MULTU_OP) begin
         p   = sa * sb;
         hi  = p[63:32];
         lo  = p[31:0];
         lat = 2;
      end else if (b == 32'd0) begin
         hi  = a;
         lo  = 32'hFFFF_FFFF;
         lat = 1;
      end else begin
         q   = sa / sb;
         r   = sa % sb;
         hi  = r[31:0];
         lo  = q[31:0];
         lat = 33;
      end
   endfunction

   task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh;
      logic [31:0] el;
      int lat;
      int cyc;
      int stalls;
      bit seen;
      ref_model(op, a, b, eh, el, lat);
      @(posedge clk); #1;
      alucontrol = op; num1 = a; num2 = b; start = 1'b1; flush = 1'b0;
      #1;
      cyc = 0; stalls = 0; seen = 1'b0;
      // start stays high through the result cycle, as the instruction sits in EXE.
      while (!seen && cyc < 100) begin
         if (ready) seen = 1'b1;
         else begin
            if (stall) stalls++;
            @(posedge clk); #2;
            cyc++;
         end
      end
      check({tag, " ready_cycle"}, 64'(cyc), 64'(lat));
      check({tag, " stall_cycles"}, 64'(stalls), 64'(lat));
      check({tag, " stall_at_done"}, 64'(stall), 64'd0);
      check({tag, " hi"}, 64'(hi_o), 64'(eh));
      check({tag, " lo"}, 64'(lo_o), 64'(el));
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      check({tag, " single_pulse"}, 64'(ready), 64'd0);
      check({tag, " hi_hold"}, 64'(hi_o), 64'(eh));
      last_hi = eh;
      last_lo = el;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ops [4];
      logic [7:0] rop;
      logic [31:0] ra;
      logic [31:0] rb;
      bit got_ready;
      ops[0] = EXE_MULT_OP; ops[1] = EXE_MULTU_OP; ops[2] = EXE_DIV_OP; ops[3] = EXE_DIVU_OP;

      rst = 1'b1; start = 1'b0; flush = 1'b0; num1 = 32'd0; num2 = 32'd0; alucontrol = 8'd0;
      @(posedge clk); @(posedge clk); #2;
      check("reset stall", 64'(stall), 64'd0);
      check("reset ready", 64'(ready), 64'd0);
      check("reset hi", 64'(hi_o), 64'd0);
      check("reset lo", 64'(lo_o), 64'd0);
      #1; rst = 1'b0;

      // Non-mult/div op with start is ignored.
      @(posedge clk); #1;
      alucontrol = 8'h20; num1 = 32'd5; num2 = 32'd3; start = 1'b1; #1;
      check("other_op stall", 64'(stall), 64'd0);
      @(posedge clk); #2;
      check("other_op ready", 64'(ready), 64'd0);
      check("other_op stall2", 64'(stall), 64'd0);
      start = 1'b0;

      run_op("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7);
      run_op("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
      run_op("mult_m1_2", EXE_MULT_OP, 32'hFFFF_FFFF, 32'd2);
      run_op("multu_m1_2", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2);
      run_op("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div_by0", EXE_DIV_OP, 32'hFFFF_0001, 32'd0);
      run_op("divu_by0", EXE_DIVU_OP, 32'h0000_1234, 32'd0);

      // Flush of DIV 1000/3 in cycle 10.
      got_ready = 1'b0;
      @(posedge clk); #1;
      alucontrol = EXE_DIV_OP; num1 = 32'd1000; num2 = 32'd3; start = 1'b1; #1;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #2;
         if (ready) got_ready = 1'b1;
      end
      check("flush pre stall", 64'(stall), 64'd1);
      @(posedge clk); #1;
      flush = 1'b1; #1;
      if (ready) got_ready = 1'b1;
      check("flush cycle stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0; #1;
      if (ready) got_ready = 1'b1;
      check("flush idle stall", 64'(stall), 64'd0);
      check("flush no ready", 64'(got_ready), 64'd0);
      check("flush hi kept", 64'(hi_o), 64'(last_hi));
      check("flush lo kept", 64'(lo_o), 64'(last_lo));
      run_op("divu_9_3_after_flush", EXE_DIVU_OP, 32'd9, 32'd3);

      // Flush and start in the same idle cycle: nothing accepted.
      @(posedge clk); #1;
      alucontrol = EXE_MULT_OP; num1 = 32'd7; num2 = 32'd9; start = 1'b1; flush = 1'b1; #1;
      check("flush_start stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0; #1;
      check("flush_start ready1", 64'(ready), 64'd0);
      @(posedge clk); #2;
      check("flush_start ready2", 64'(ready), 64'd0);
      check("flush_start hi kept", 64'(hi_o), 64'(last_hi));

      // Random ops with boundary-biased operands.
      for (int i = 0; i < 24; i++) begin
         rop = ops[$urandom_range(0, 3)];
         ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), rop, ra, rb);
      end

      run_op("mult_pre_reset", EXE_MULT_OP, 32'd12345, 32'hFFFF_FF00);

      // Reset in cycle 5 of a DIV.
      @(posedge clk); #1;
      alucontrol = EXE_DIV_OP; num1 = 32'd1000; num2 = 32'd3; start = 1'b1; #1;
      repeat (4) begin @(posedge clk); #2; end
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0; #1;
      @(posedge clk); #2;
      check("rst_mid stall", 64'(stall), 64'd0);
      check("rst_mid ready", 64'(ready), 64'd0);
      check("rst_mid hi", 64'(hi_o), 64'd0);
      check("rst_mid lo", 64'(lo_o), 64'd0);
      rst = 1'b0;
      run_op("divu_after_rst", EXE_DIVU_OP, 32'd1000, 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide controller beside the single-cycle ALU in the EXE stage. Accepts MULT/MULTU/DIV/DIVU ops decoded from the same 8-bit alucontrol space and sequences an iterative restoring divider or a registered multiplier. Holds the pipeline via stall until the result is ready, then delivers a 64-bit {hi,lo} result for HILO writeback. Supports flush/annul mid-operation.

Parameters:
DIV_CYCLES, 32, number of divider iterations (one quotient bit per cycle); fixed at 32 for 32-bit operands.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
num1  in  32  rs operand (dividend / multiplicand).
num2  in  32  rt operand (divisor / multiplier).
alucontrol  in  8  op code; only EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP act.
start  in  1  EXE holds a valid mult/div instruction.
flush  in  1  annul in-flight op (exception/branch flush).
stall  out  1  combinational; hold IF/ID/EXE this cycle.
ready  out  1  registered; one-cycle pulse, hi_o/lo_o valid.
hi_o  out  32  HI result (remainder / product[63:32]).
lo_o  out  32  LO result (quotient / product[31:0]).

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. Reset: state=IDLE, counter=0, ready=0, hi_o=0, lo_o=0, all operand/partial registers 0.
- States: IDLE, MULT, DIV, DONE.
- IDLE: start=1 with mult/div op and flush=0 -> latch operands and op, stall=1 this cycle. MULT/MULTU -> MULT. DIV/DIVU with num2!=0 -> DIV, counter=0. num2==0 -> DONE with hi_o=num1, lo_o=32'hFFFFFFFF. start with any other op ignored, stall=0.
- MULT: register full 64-bit product (signed for MULT, unsigned for MULTU); stall=1; -> DONE.
- DIV: signed ops operate on magnitudes (abs via two's complement). Each cycle shift {rem,quot} left 1, trial-subtract divisor from rem[32:0] (33-bit); nonnegative -> keep, quot bit=1. counter increments; at counter==31 -> DONE. stall=1 throughout.
- DONE: ready=1, stall=0, hi_o/lo_o hold result. Signed fix-up: quotient negated if operand signs differ; remainder takes dividend sign. start ignored (same instruction still in EXE). -> IDLE next cycle.
- Latency from accept cycle (cycle 0): DIV/DIVU ready in cycle 33 (stall 33 cycles); MULT/MULTU ready in cycle 2; divide-by-zero ready in cycle 1.
- hi_o/lo_o updated only on entering DONE; hold value afterwards until next result. ready low outside DONE.
- flush=1 in any state -> IDLE next cycle, ready=0, hi_o/lo_o unchanged, stall=0 that cycle. flush and start in the same IDLE cycle: flush wins, nothing accepted.
- Overflow: none; DIV of 0x80000000 by -1 yields lo=0x80000000, hi=0 (MIPS undefined case, fixed here for determinism).
- rst in any state overrides flush/start.

Decomposition:
- Op codes EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP live in the shared defines include with the other EXE_*_OP macros; state encodings local localparams.
- One natural sub-module: div_iter (one restoring-divide step: 33-bit trial subtract plus shift), instantiated once, combinational.

Test Plan:
- DIVU num1=100, num2=7, start at cycle 0 -> stall high cycles 0..32, ready in cycle 33, lo_o=14, hi_o=2.
- DIV num1=0xFFFFFFF9 (-7), num2=2 -> ready in cycle 33, lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1).
- MULT 0xFFFFFFFF x 2 -> ready in cycle 2, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE; MULTU same operands -> hi_o=1, lo_o=0xFFFFFFFE.
- DIVU num1=0x1234, num2=0 -> ready in cycle 1, hi_o=0x1234, lo_o=0xFFFFFFFF.
- DIV 1000/3 with flush in cycle 10 -> state IDLE cycle 11, no ready pulse, hi_o/lo_o keep prior values; new DIVU 9/3 accepted cycle 12 -> lo_o=3, hi_o=0 at cycle 45.
- rst asserted in cycle 5 of a DIV -> cycle 6: stall=0, ready=0, hi_o=lo_o=0; start held high through DONE -> exactly one ready pulse per op.
